// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: classifies each instruction format, builds
// the XLEN-wide immediate and an illegal flag, and queues the result in a small
// in-order FIFO that decouples fetch from execute.
module imm_decode_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_fmt,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_shift;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [63:0] dec_imm64;
  fmt_e        dec_fmt;
  logic        dec_illegal;
  entry_t      new_entry;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Immediates are built 64 bits wide and truncated; sign extension to 64 then
  // truncation equals sign extension to XLEN for both legal widths.
  assign imm_i = {{52{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{52{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
  assign imm_j = {{44{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // Format classification, immediate selection and legality check of the input word
  always_comb begin
    dec_fmt     = FMT_NONE;
    dec_imm64   = '0;
    dec_illegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      unique case (opcode)
        7'b0010011: begin
          dec_fmt = FMT_I;
          if (is_shift) begin
            if (XLEN == 64) begin
              dec_imm64 = {58'b0, in_instr[25:20]};
            end else begin
              dec_imm64   = {59'b0, in_instr[24:20]};
              dec_illegal = in_instr[25];
            end
          end else begin
            dec_imm64 = imm_i;
          end
        end
        7'b0000011, 7'b1100111, 7'b1110011: begin
          dec_fmt   = FMT_I;
          dec_imm64 = imm_i;
        end
        7'b0011011: begin
          if (XLEN == 64) begin
            dec_fmt = FMT_I;
            if (is_shift) begin
              dec_imm64   = {59'b0, in_instr[24:20]};
              dec_illegal = in_instr[25];
            end else begin
              dec_imm64 = imm_i;
            end
          end else begin
            dec_illegal = 1'b1;
          end
        end
        7'b0100011: begin
          dec_fmt   = FMT_S;
          dec_imm64 = imm_s;
        end
        7'b1100011: begin
          dec_fmt   = FMT_B;
          dec_imm64 = imm_b;
        end
        7'b0110111, 7'b0010111: begin
          dec_fmt   = FMT_U;
          dec_imm64 = imm_u;
        end
        7'b1101111: begin
          dec_fmt   = FMT_J;
          dec_imm64 = imm_j;
        end
        7'b0110011: begin
          dec_fmt = FMT_NONE;
        end
        7'b0111011: begin
          dec_illegal = (XLEN != 64);
        end
        default: begin
          dec_illegal = 1'b1;
        end
      endcase
    end
    if (dec_illegal) begin
      dec_fmt   = FMT_NONE;
      dec_imm64 = '0;
    end
  end

  // Pack the decoded result into a FIFO entry
  always_comb begin
    new_entry         = '0;
    new_entry.instr   = in_instr;
    new_entry.pc      = in_pc;
    new_entry.imm     = dec_imm64[XLEN-1:0];
    new_entry.fmt     = dec_fmt;
    new_entry.illegal = dec_illegal;
  end

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic             push, pop;
  entry_t           head;

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem_q[rd_ptr_q];

  // FIFO next state; flush discards everything including a same-cycle push
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  // Head payload, forced to zero whenever nothing is valid
  always_comb begin
    out_instr   = '0;
    out_pc      = '0;
    out_imm     = '0;
    out_fmt     = '0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_instr   = head.instr;
      out_pc      = head.pc;
      out_imm     = head.imm;
      out_fmt     = head.fmt;
      out_illegal = head.illegal;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: an XLEN=64 and an XLEN=32 instance share one
// input stream; a queue-based model predicts both every cycle.
module tb_imm_decode_stage;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        r64, ov64, ill64;
  logic [31:0] oi64;
  logic [63:0] opc64, imm64;
  logic [2:0]  fmt64;
  logic [1:0]  cnt64;

  logic        r32, ov32, ill32;
  logic [31:0] oi32;
  logic [31:0] opc32, imm32;
  logic [2:0]  fmt32;
  logic [1:0]  cnt32;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(64), .DEPTH(DEPTH)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(ov64), .out_ready(out_ready), .out_instr(oi64), .out_pc(opc64),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .count(cnt64)
  );

  imm_decode_stage #(.XLEN(32), .DEPTH(DEPTH)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(r32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
    .out_valid(ov32), .out_ready(out_ready), .out_instr(oi32), .out_pc(opc32),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .count(cnt32)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
    logic [63:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Sign-extend the low n bits of v to 64 bits.
  function automatic logic [63:0] sx(input int unsigned n, input logic [63:0] v);
    logic signed [63:0] t;
    t = $signed(v << (64 - n));
    return 64'(t >>> (64 - n));
  endfunction

  task automatic dec(input logic [31:0] ins, input bit is64,
                     output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
    logic [63:0] w;
    int unsigned op, f3;
    bit          sh;
    w   = {32'b0, ins};
    op  = 32'(ins[6:0]);
    f3  = 32'(ins[14:12]);
    sh  = (f3 == 1) || (f3 == 5);
    imm = 64'd0;
    fmt = 3'd0;
    ill = 1'b0;
    if (ins[1:0] != 2'b11) ill = 1'b1;
    else begin
      case (op)
        'h13: begin
          fmt = 3'd1;
          if (sh) begin
            if (is64) imm = (w >> 20) & 64'd63;
            else begin
              imm = (w >> 20) & 64'd31;
              ill = ins[25];
            end
          end else imm = sx(12, w >> 20);
        end
        'h03, 'h67, 'h73: begin
          fmt = 3'd1;
          imm = sx(12, w >> 20);
        end
        'h1B: begin
          if (!is64) ill = 1'b1;
          else begin
            fmt = 3'd1;
            if (sh) begin
              imm = (w >> 20) & 64'd31;
              ill = ins[25];
            end else imm = sx(12, w >> 20);
          end
        end
        'h23: begin
          fmt = 3'd2;
          imm = sx(12, ((w >> 25) << 5) | ((w >> 7) & 64'd31));
        end
        'h63: begin
          fmt = 3'd3;
          imm = sx(13, ((w >> 31) << 12) | (((w >> 7) & 64'd1) << 11) |
                       (((w >> 25) & 64'd63) << 5) | (((w >> 8) & 64'd15) << 1));
        end
        'h37, 'h17: begin
          fmt = 3'd4;
          imm = sx(32, w & 64'hFFFF_F000);
        end
        'h6F: begin
          fmt = 3'd5;
          imm = sx(21, ((w >> 31) << 20) | (((w >> 12) & 64'd255) << 12) |
                       (((w >> 20) & 64'd1) << 11) | (((w >> 21) & 64'd1023) << 1));
        end
        'h33: fmt = 3'd0;
        'h3B: ill = !is64;
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      imm = 64'd0;
      fmt = 3'd0;
    end
  endtask

  // Reference queue: reset/flush empty it, otherwise pop head then append input.
  always @(posedge clk) begin
    exp_t e;
    bit   do_pop, do_push;
    started <= 1'b1;
    if (rst || flush) q.delete();
    else begin
      do_pop  = out_ready && (q.size() > 0);
      do_push = in_valid && (q.size() < DEPTH);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.instr = in_instr;
        e.pc    = in_pc;
        dec(in_instr, 1'b1, e.imm64, e.fmt64, e.ill64);
        dec(in_instr, 1'b0, e.imm32, e.fmt32, e.ill32);
        q.push_back(e);
      end
    end
  end

  // Every-cycle comparison of both instances against the reference queue.
  always @(negedge clk) begin
    exp_t h;
    bit   v;
    if (started) begin
      v = (q.size() != 0);
      if (v) h = q[0];
      else begin
        h.instr = '0; h.pc = '0;
        h.imm64 = '0; h.fmt64 = '0; h.ill64 = 1'b0;
        h.imm32 = '0; h.fmt32 = '0; h.ill32 = 1'b0;
      end
      chk("u64.out_valid", 64'(ov64), 64'(v));
      chk("u64.in_ready", 64'(r64), 64'(q.size() < DEPTH));
      chk("u64.count", 64'(cnt64), 64'(q.size()));
      chk("u64.out_instr", 64'(oi64), 64'(h.instr));
      chk("u64.out_pc", opc64, h.pc);
      chk("u64.out_imm", imm64, h.imm64);
      chk("u64.out_fmt", 64'(fmt64), 64'(h.fmt64));
      chk("u64.out_illegal", 64'(ill64), 64'(h.ill64));
      chk("u32.out_valid", 64'(ov32), 64'(v));
      chk("u32.in_ready", 64'(r32), 64'(q.size() < DEPTH));
      chk("u32.count", 64'(cnt32), 64'(q.size()));
      chk("u32.out_instr", 64'(oi32), 64'(h.instr));
      chk("u32.out_pc", 64'(opc32), 64'(h.pc[31:0]));
      chk("u32.out_imm", 64'(imm32), 64'(h.imm32[31:0]));
      chk("u32.out_fmt", 64'(fmt32), 64'(h.fmt32));
      chk("u32.out_illegal", 64'(ill32), 64'(h.ill32));
    end
  end

  // Apply one cycle of inputs, then return just after the following falling edge.
  task automatic cyc(input bit v, input logic [31:0] ins, input bit ordy,
                     input bit fl, input bit rs);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = {$urandom(), $urandom()};
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(negedge clk);
    #1;
  endtask

  logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h1B, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B};

  initial begin
    logic [31:0] ins;
    cyc(0, 32'h0, 0, 0, 1);
    cyc(0, 32'h0, 0, 0, 1);
    chk("lit.reset.count", 64'(cnt64), 64'd0);
    chk("lit.reset.in_ready", 64'(r64), 64'd1);
    chk("lit.reset.out_valid", 64'(ov64), 64'd0);

    // ADDI -1
    cyc(1, 32'hFFF00093, 0, 0, 0);
    chk("lit.addi.valid", 64'(ov64), 64'd1);
    chk("lit.addi.fmt", 64'(fmt64), 64'd1);
    chk("lit.addi.imm", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lit.addi.ill", 64'(ill64), 64'd0);
    chk("lit.addi.imm32", 64'(imm32), 64'hFFFF_FFFF);
    cyc(0, 32'h0, 1, 0, 0);

    // LUI pair, in order
    cyc(1, 32'h123450B7, 0, 0, 0);
    cyc(1, 32'h800000B7, 0, 0, 0);
    chk("lit.lui1.imm", imm64, 64'h0000_0000_1234_5000);
    chk("lit.lui1.fmt", 64'(fmt64), 64'd4);
    cyc(0, 32'h0, 1, 0, 0);
    chk("lit.lui2.imm", imm64, 64'hFFFF_FFFF_8000_0000);
    chk("lit.lui2.fmt", 64'(fmt64), 64'd4);
    cyc(0, 32'h0, 1, 0, 0);

    // JAL -4, then BEQ +8 pushed while JAL pops
    cyc(1, 32'hFFDFF06F, 0, 0, 0);
    chk("lit.jal.fmt", 64'(fmt64), 64'd5);
    chk("lit.jal.imm", imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(1, 32'h00000463, 1, 0, 0);
    chk("lit.beq.fmt", 64'(fmt64), 64'd3);
    chk("lit.beq.imm", imm64, 64'h8);
    cyc(0, 32'h0, 1, 0, 0);

    // SLLI 63: legal on RV64, illegal on RV32
    cyc(1, 32'h03F09093, 0, 0, 0);
    chk("lit.slli64.imm", imm64, 64'd63);
    chk("lit.slli64.fmt", 64'(fmt64), 64'd1);
    chk("lit.slli64.ill", 64'(ill64), 64'd0);
    chk("lit.slli32.ill", 64'(ill32), 64'd1);
    chk("lit.slli32.imm", 64'(imm32), 64'd0);
    chk("lit.slli32.fmt", 64'(fmt32), 64'd0);
    cyc(0, 32'h0, 1, 0, 0);

    // RV64-only R opcode, then an unknown opcode
    cyc(1, 32'h0000003B, 0, 0, 0);
    chk("lit.op3b32.ill", 64'(ill32), 64'd1);
    chk("lit.op3b64.ill", 64'(ill64), 64'd0);
    cyc(1, 32'h0000007F, 1, 0, 0);
    chk("lit.op7f.ill", 64'(ill64), 64'd1);
    chk("lit.op7f.fmt", 64'(fmt64), 64'd0);
    cyc(0, 32'h0, 1, 0, 0);

    // Backpressure: third offer waits until the cycle after the first pop
    cyc(1, 32'h00100093, 0, 0, 0);
    cyc(1, 32'h00200093, 0, 0, 0);
    chk("lit.full.count", 64'(cnt64), 64'd2);
    chk("lit.full.in_ready", 64'(r64), 64'd0);
    cyc(1, 32'h00300093, 0, 0, 0);
    chk("lit.full.count2", 64'(cnt64), 64'd2);
    cyc(1, 32'h00300093, 1, 0, 0);
    chk("lit.pop1.count", 64'(cnt64), 64'd1);
    chk("lit.pop1.in_ready", 64'(r64), 64'd1);
    chk("lit.pop1.head", 64'(oi64), 64'h00200093);
    cyc(1, 32'h00300093, 1, 0, 0);
    chk("lit.pop2.head", 64'(oi64), 64'h00300093);
    cyc(0, 32'h0, 1, 0, 0);

    // Flush with a simultaneous push
    cyc(1, 32'h00100093, 0, 0, 0);
    cyc(1, 32'h00200093, 0, 0, 0);
    cyc(1, 32'h00300093, 0, 1, 0);
    chk("lit.flush.count", 64'(cnt64), 64'd0);
    chk("lit.flush.valid", 64'(ov64), 64'd0);
    chk("lit.flush.in_ready", 64'(r64), 64'd1);
    cyc(0, 32'h0, 0, 0, 0);
    chk("lit.flush.count2", 64'(cnt64), 64'd0);

    // Reset with a simultaneous push
    cyc(1, 32'h00100093, 0, 0, 0);
    cyc(1, 32'h00200093, 0, 0, 0);
    cyc(1, 32'h00300093, 1, 0, 1);
    chk("lit.rst.count", 64'(cnt64), 64'd0);
    chk("lit.rst.valid", 64'(ov64), 64'd0);
    chk("lit.rst.instr", 64'(oi64), 64'd0);
    chk("lit.rst.imm", imm64, 64'd0);
    cyc(0, 32'h0, 1, 0, 0);
    chk("lit.rst.valid2", 64'(ov64), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ins = $urandom();
      if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 11)];
      cyc($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0,
          $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(0, 32'h0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered immediate-decode stage for the RV64/RV32 integer front end. It accepts one instruction word plus PC per cycle over a valid/ready handshake and classifies the instruction format. It builds the XLEN-wide sign- or zero-extended immediate and flags unsupported encodings. Results sit in a small in-order FIFO, so fetch and execute are decoupled and backpressure never combinationally crosses the stage.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all stored entries; synchronous.
- in_valid  in  1  producer offers in_instr/in_pc.
- in_ready  out  1  stage can accept; high iff count < DEPTH.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  XLEN  head PC.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  0=none/R, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_illegal  out  1  encoding not supported.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Push: in_valid && in_ready. Pop: out_valid && out_ready. Decode is combinational on the input side and is stored with the entry.
- If in_instr[1:0] != 2'b11, the entry is illegal.
- Opcode map:
  - I: 0010011, 0000011, 1100111, 1110011, and 0011011 when XLEN=64.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - R: 0110011, and 0111011 when XLEN=64.
- Any other opcode, or a 64-bit-only opcode when XLEN=32, is illegal.
- I immediate: sign-extend instr[31:20].
- S immediate: sign-extend {instr[31:25], instr[11:7]}.
- B immediate: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- U immediate: sign-extend {instr[31:12], 12'b0}.
- J immediate: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Shifts in opcode 0010011 with funct3 001/101:
  - XLEN=64: imm = zero-extended instr[25:20].
  - XLEN=32: imm = zero-extended instr[24:20]; instr[25]=1 is illegal.
- Shifts in opcode 0011011 (XLEN=64 only): imm = zero-extended instr[24:20]; instr[25]=1 is illegal.
- R and illegal entries: out_imm=0. Illegal entries: out_fmt=0. Illegal entries are still queued and delivered, never dropped.
- FIFO: in-order; read and write pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Push when full cannot happen, because in_ready is low.
  - Pop when empty cannot happen, because out_valid is low.
- When out_valid=0, all out_* payload outputs are driven to 0.
- flush: count, read pointer and write pointer go to 0. flush overrides any push and pop in the same cycle, so the pushed instruction is lost. in_ready is high the next cycle.

## Timing
- Reset values: count=0, out_valid=0, in_ready=1 from the first cycle after rst, all payload outputs 0, both pointers 0. rst has priority over flush and push.
- Latency: an entry pushed at edge N is visible on out_* after edge N. With an empty FIFO, that is 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- in_ready depends only on registered count, with no path from out_ready. A full FIFO popped in cycle N shows in_ready=1 in cycle N+1.
- Outputs are stable while out_valid && !out_ready. The head changes only on pop, flush or rst.
- rst asserted mid-stream: all entries are lost and no out_valid pulse appears after the reset edge.

## Test plan
- XLEN=64; push 0xFFF00093 (ADDI -1) -> out_fmt=1, out_imm=0xFFFFFFFFFFFFFFFF, out_illegal=0, one cycle after accept.
- Push 0x123450B7, then 0x800000B7 (LUI) -> imm 0x0000000012345000, then 0xFFFFFFFF80000000, both fmt=4, in order.
- Push 0xFFDFF06F (JAL -4) -> fmt=5, imm 0xFFFFFFFFFFFFFFFC. Push 0x00000463 (BEQ +8) -> fmt=3, imm 0x8.
- Push 0x03F09093 (SLLI 63): XLEN=64 -> imm=63, fmt=1, legal. XLEN=32 -> out_illegal=1, imm=0. Push 0x0000003B in XLEN=32 -> illegal; opcode 0x7F -> illegal with fmt=0.
- DEPTH=2, out_ready=0; offer 3 instructions -> in_ready low after 2 accepts, count=2. Then out_ready=1 -> entries emerge in order, and the third is accepted in the cycle after the first pop.
- Fill 2 entries, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, pushed word absent. Repeat with rst instead -> same, all outputs 0.
